// File: rtl/dual_wb_queue_pkg.sv
// Shared definitions for the dual-issue writeback queue.
//   REG_ZERO          : architectural $zero register index.
//   lane_t            : one lane's write record {we, rd, data} = 1+5+32 = 38 bits.
//   bundle_t          : one issue bundle {lane 1, lane 0} = 76 bits.
//   resolve_bundle()  : push-time filter that drops $zero writes and resolves
//                       same-bundle write-after-write conflicts (younger lane wins).
package dual_wb_queue_pkg;

  localparam int REG_W    = 5;
  localparam int DATA_W   = 32;
  localparam int LANE_W   = 1 + REG_W + DATA_W;
  localparam int BUNDLE_W = 2 * LANE_W;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  // Field order fixes the packed layout: we is the MSB, data the LSBs.
  typedef struct packed {
    logic              we;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } lane_t;

  // Lane 1 sits in the upper half, lane 0 in the lower half.
  typedef struct packed {
    lane_t l1;
    lane_t l0;
  } bundle_t;

  // Only the filtered enables are stored, so the register file never sees a
  // write to $zero, and it never sees two writes to one register on one edge.
  function automatic bundle_t resolve_bundle(
    input logic              we0,
    input logic [REG_W-1:0]  reg0,
    input logic [DATA_W-1:0] data0,
    input logic              we1,
    input logic [REG_W-1:0]  reg1,
    input logic [DATA_W-1:0] data1
  );
    bundle_t b;
    logic    e0;
    logic    e1;
    e1 = we1 && (reg1 != REG_ZERO);
    e0 = we0 && (reg0 != REG_ZERO) && !(e1 && (reg1 == reg0));
    b.l0 = '{we: e0, rd: reg0, data: data0};
    b.l1 = '{we: e1, rd: reg1, data: data1};
    return b;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Parameterised synchronous FIFO with asynchronous active-high reset.
//   clk, reset      : clock (rising edge) and async active-high reset.
//   push, wdata     : write request and data; ignored while full.
//   pop,  rdata     : read request; rdata always shows the head entry.
//   full, empty     : occupancy flags.
//   count           : current occupancy, 0..DEPTH.
// DEPTH must be a power of two, so the pointers wrap on their own.
module wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNTW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values, whatever the statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CNTW'(do_push) - CNTW'(do_pop);
    end
  end

  // NOTE: the storage array has no reset; count alone says which slots hold
  // live data, and leaving the array unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/dual_wb_queue.sv
// Writeback queue for the dual-issue pipeline.
//   clk, reset                     : clock (rising edge), async active-high reset.
//   in_valid / in_ready            : bundle handshake; in_ready = !full.
//   in_we0/in_reg0/in_data0        : lane 0 (older) write request.
//   in_we1/in_reg1/in_data1        : lane 1 (younger) write request.
//   wb_stall                       : hold the head entry this cycle.
//   regwrite/wrreg/wrdata          : registered register-file write port 0.
//   regwrite1/wrreg1/wrdata1       : registered register-file write port 1.
//   busy                           : per-register pending-write flags (bit 0 always 0).
//   count                          : FIFO occupancy.
// A pushed bundle reaches the write outputs one edge after the push at the
// earliest; there is no push-to-output bypass.
module dual_wb_queue
  import dual_wb_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH+2)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_we0,
  input  logic [4:0]                   in_reg0,
  input  logic [31:0]                  in_data0,
  input  logic                         in_we1,
  input  logic [4:0]                   in_reg1,
  input  logic [31:0]                  in_data1,
  input  logic                         wb_stall,
  output logic                         regwrite,
  output logic [4:0]                   wrreg,
  output logic [31:0]                  wrdata,
  output logic                         regwrite1,
  output logic [4:0]                   wrreg1,
  output logic [31:0]                  wrdata1,
  output logic [31:0]                  busy,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  bundle_t         in_bundle;
  bundle_t         head;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic [31:1]     inc;
  logic [31:1]     dec;
  logic [CW-1:0]   pend [1:31];

  assign in_bundle = resolve_bundle(in_we0, in_reg0, in_data0,
                                    in_we1, in_reg1, in_data1);

  // A full queue refuses a push even if the head pops on the same edge.
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign pop      = !empty && !wb_stall;

  wb_fifo #(
    .WIDTH (BUNDLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (in_bundle),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Write-port registers. Without a pop only the strobes drop; the address
  // and data hold, which saves toggling on the register-file inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regwrite  <= 1'b0;
      wrreg     <= '0;
      wrdata    <= '0;
      regwrite1 <= 1'b0;
      wrreg1    <= '0;
      wrdata1   <= '0;
    end else if (pop) begin
      regwrite  <= head.l0.we;
      wrreg     <= head.l0.rd;
      wrdata    <= head.l0.data;
      regwrite1 <= head.l1.we;
      wrreg1    <= head.l1.rd;
      wrdata1   <= head.l1.data;
    end else begin
      regwrite  <= 1'b0;
      regwrite1 <= 1'b0;
    end
  end

  // Increments come from the bundle being pushed, decrements from the writes
  // the register file is committing at this edge. Resolution guarantees each
  // side contributes at most one to any register.
  // NOTE: every bit gets a value on every path through the always_comb (here
  // via the loop covering the whole range), so no latch can be inferred.
  always_comb begin
    for (int r = 1; r < 32; r++) begin
      inc[r] = push && ((in_bundle.l0.we && (in_bundle.l0.rd == 5'(r))) ||
                        (in_bundle.l1.we && (in_bundle.l1.rd == 5'(r))));
      dec[r] = (regwrite  && (wrreg  == 5'(r))) ||
               (regwrite1 && (wrreg1 == 5'(r)));
    end
  end

  // Pending count covers entries in the FIFO plus the write on the outputs,
  // so it never exceeds DEPTH+1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 1; r < 32; r++) pend[r] <= '0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        assert (!(dec[r] && (pend[r] == '0)));
        pend[r] <= pend[r] + CW'(inc[r]) - CW'(dec[r]);
      end
    end
  end

  always_comb begin
    busy[0] = 1'b0;
    for (int r = 1; r < 32; r++) busy[r] = (pend[r] != '0);
  end

endmodule

// File: tb/tb_dual_wb_queue.sv
module tb_dual_wb_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_we0;
  logic [4:0]  in_reg0;
  logic [31:0] in_data0;
  logic        in_we1;
  logic [4:0]  in_reg1;
  logic [31:0] in_data1;
  logic        wb_stall;
  logic        regwrite;
  logic [4:0]  wrreg;
  logic [31:0] wrdata;
  logic        regwrite1;
  logic [4:0]  wrreg1;
  logic [31:0] wrdata1;
  logic [31:0] busy;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  dual_wb_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_we0    (in_we0),
    .in_reg0   (in_reg0),
    .in_data0  (in_data0),
    .in_we1    (in_we1),
    .in_reg1   (in_reg1),
    .in_data1  (in_data1),
    .wb_stall  (wb_stall),
    .regwrite  (regwrite),
    .wrreg     (wrreg),
    .wrdata    (wrdata),
    .regwrite1 (regwrite1),
    .wrreg1    (wrreg1),
    .wrdata1   (wrdata1),
    .busy      (busy),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of bundles with writes already filtered, plus
  // the two write ports as the register file would see them.
  typedef struct {
    bit        e0;
    bit [4:0]  r0;
    bit [31:0] d0;
    bit        e1;
    bit [4:0]  r1;
    bit [31:0] d1;
  } mb_t;

  mb_t       mq[$];
  bit        m_rw0, m_rw1;
  bit [4:0]  m_wr0, m_wr1;
  bit [31:0] m_wd0, m_wd1;

  function automatic bit [31:0] model_busy();
    bit [31:0] b = '0;
    foreach (mq[i]) begin
      if (mq[i].e0) b[mq[i].r0] = 1'b1;
      if (mq[i].e1) b[mq[i].r1] = 1'b1;
    end
    if (m_rw0) b[m_wr0] = 1'b1;
    if (m_rw1) b[m_wr1] = 1'b1;
    return b;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_rw0 = 0; m_rw1 = 0;
    m_wr0 = 0; m_wr1 = 0;
    m_wd0 = 0; m_wd1 = 0;
  endtask

  // Applies one clock edge to the model using the inputs present at the edge.
  task automatic model_edge();
    bit  do_push;
    bit  do_pop;
    mb_t nb;
    do_push = in_valid && (mq.size() < DEPTH);
    do_pop  = (mq.size() > 0) && !wb_stall;
    nb.e1 = in_we1 && (in_reg1 != 0);
    nb.e0 = in_we0 && (in_reg0 != 0) && !(nb.e1 && in_reg1 == in_reg0);
    nb.r0 = in_reg0; nb.d0 = in_data0;
    nb.r1 = in_reg1; nb.d1 = in_data1;
    if (do_pop) begin
      mb_t h = mq.pop_front();
      m_rw0 = h.e0; m_wr0 = h.r0; m_wd0 = h.d0;
      m_rw1 = h.e1; m_wr1 = h.r1; m_wd1 = h.d1;
    end else begin
      m_rw0 = 0;
      m_rw1 = 0;
    end
    if (do_push) mq.push_back(nb);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".in_ready"},  32'(in_ready),  32'(mq.size() < DEPTH));
    check({tag, ".count"},     32'(count),     32'(mq.size()));
    check({tag, ".regwrite"},  32'(regwrite),  32'(m_rw0));
    check({tag, ".wrreg"},     32'(wrreg),     32'(m_wr0));
    check({tag, ".wrdata"},    wrdata,         m_wd0);
    check({tag, ".regwrite1"}, 32'(regwrite1), 32'(m_rw1));
    check({tag, ".wrreg1"},    32'(wrreg1),    32'(m_wr1));
    check({tag, ".wrdata1"},   wrdata1,        m_wd1);
    check({tag, ".busy"},      busy,           model_busy());
  endtask

  task automatic step(input string tag, input bit v, input bit we0, input bit [4:0] r0,
                      input bit [31:0] d0, input bit we1, input bit [4:0] r1,
                      input bit [31:0] d1, input bit stall);
    in_valid = v;
    in_we0 = we0; in_reg0 = r0; in_data0 = d0;
    in_we1 = we1; in_reg1 = r1; in_data1 = d1;
    wb_stall = stall;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input bit stall, input int n);
    for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0, 0, 0, 0, stall);
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 0; in_we0 = 0; in_reg0 = 0; in_data0 = 0;
    in_we1 = 0; in_reg1 = 0; in_data1 = 0; wb_stall = 0;
    model_reset();
    #3;
    check_all("reset");
    #9 reset = 1'b0;   // released between edges
    idle("post_reset", 0, 1);

    // Single lane-0 write: visible after k+1, strobe gone after k+2.
    step("single_push", 1, 1, 8, 32'hDEADBEEF, 0, 0, 0, 0);
    check("single_busy8_k", 32'(busy[8]), 32'd1);
    idle("single_out", 0, 1);
    check("single_regwrite", 32'(regwrite), 32'd1);
    idle("single_done", 0, 2);
    check("single_busy8_clear", 32'(busy[8]), 32'd0);

    // Same-register conflict: lane 1 wins.
    step("conflict_push", 1, 1, 9, 32'd1, 1, 9, 32'd2, 0);
    idle("conflict_out", 0, 1);
    check("conflict_regwrite1", 32'(regwrite1), 32'd1);
    idle("conflict_done", 0, 2);

    // $zero writes still take a slot.
    step("zero_push", 1, 1, 0, 32'h11, 1, 0, 32'h22, 0);
    check("zero_count", 32'(count), 32'd1);
    idle("zero_pop", 0, 2);

    // Fill under stall, fifth offer refused, then drain in order.
    for (int i = 0; i < 5; i++)
      step("fill", 1, 1, 5'(i + 1), 32'h100 + 32'(i), 1, 5'(i + 20), 32'h200 + 32'(i), 1);
    check("fill_in_ready", 32'(in_ready), 32'd0);
    idle("drain", 0, 6);

    // Pending counter depth on one register, overlapped push with pop.
    for (int i = 0; i < 3; i++) step("pend10", 1, 1, 10, 32'(i), 0, 0, 0, 1);
    step("pend10_pushpop", 1, 0, 0, 0, 1, 10, 32'hA0, 0);
    idle("pend10_drain", 0, 5);
    check("pend10_busy_clear", 32'(busy[10]), 32'd0);

    // Reset with three queued entries and a write on the outputs.
    for (int i = 0; i < 4; i++) step("prereset", 1, 1, 5'(i + 11), 32'(i), 1, 5'(i + 16), 32'(i), 1);
    step("prereset_pop", 0, 0, 0, 0, 0, 0, 0, 0);
    check("prereset_regwrite", 32'(regwrite), 32'd1);
    wb_stall = 1'b0;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    #2 reset = 1'b0;
    idle("after_reset", 0, 4);

    // Randomised traffic over a small register range to provoke conflicts.
    for (int i = 0; i < 400; i++)
      step("rand", 1'($urandom_range(0, 3) != 0),
           1'($urandom), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 9) < 3));
    idle("rand_drain", 0, DEPTH + 2);
    check("final_busy", busy, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
